// File: rtl/pattern_sched_pkg.sv
// Shared definitions for the pattern evaluation scheduler: default sizes,
// FSM states and the response FIFO payload.
package pattern_sched_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_VEC_W     = 15;
    localparam int DEF_RES_W     = 13;
    localparam int DEF_CORE_LAT  = 2;
    localparam int DEF_RSP_DEPTH = 4;
    localparam int MAX_N_REQ     = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RSP_ID_W = id_width(MAX_N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // The id field is wide enough for the largest requester count, so one
    // payload type serves every legal N_REQ.
    typedef struct packed {
        logic [RSP_ID_W-1:0]  id;
        logic [DEF_RES_W-1:0] result;
    } rsp_t;

endpackage

// File: rtl/pattern_rsp_fifo.sv
// Synchronous response FIFO holding {id, result} entries; push and pop may
// coincide in any occupancy state and the count moves by the net change.
module pattern_rsp_fifo
    import pattern_sched_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  rsp_t                       din,
    input  logic                       pop,
    output rsp_t                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // NOTE: storage carries no reset; empty/count alone decide whether the head is meaningful.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pattern_eval_scheduler.sv
// Round-robin scheduler sharing one pipelined pattern evaluation core among
// N_REQ requesters, with credit-protected in-order response return.
module pattern_eval_scheduler
    import pattern_sched_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int VEC_W     = DEF_VEC_W,
    parameter int RES_W     = DEF_RES_W,
    parameter int CORE_LAT  = DEF_CORE_LAT,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic                       blif_clk_net,
    input  logic                       blif_reset_net,
    input  logic                       cfg_enable,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*VEC_W-1:0]     req_vec,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       core_launch,
    output logic [VEC_W-1:0]           core_vec,
    input  logic [RES_W-1:0]           core_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [RES_W-1:0]           rsp_result,
    output logic                       busy
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  in_flight;

    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              grant_en;
    logic              transfer;

    logic [CORE_LAT:0] tag_valid;
    logic [ID_W-1:0]   tag_id [CORE_LAT+1];

    rsp_t              rsp_in;
    rsp_t              rsp_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign grant_en  = (state == RUN) && cfg_enable && (outstanding < CNT_W'(RSP_DEPTH));
    assign transfer  = |(req_valid & req_ready);
    assign in_flight = outstanding - fifo_count;
    assign busy      = (state != IDLE);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        winner    = '0;
        idx       = '0;
        found     = 1'b0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (grant_en && found)
            req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_enable) state_nxt = RUN;
            RUN:     if (!cfg_enable) state_nxt = DRAIN;
            DRAIN: begin
                if (cfg_enable)
                    state_nxt = RUN;
                else if (in_flight == '0 && fifo_empty)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net) begin
        if (!blif_reset_net) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            outstanding <= '0;
            core_launch <= 1'b0;
            core_vec    <= '0;
            tag_valid   <= '0;
            for (int s = 0; s <= CORE_LAT; s++)
                tag_id[s] <= '0;
        end else begin
            state       <= state_nxt;
            core_launch <= transfer;
            if (transfer) begin
                core_vec <= req_vec[int'(winner)*VEC_W +: VEC_W];
                rr_ptr   <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
            end
            // Stage 0 lines up with core_launch; the last stage with core_result.
            tag_valid <= {tag_valid[CORE_LAT-1:0], transfer};
            tag_id[0] <= winner;
            for (int s = 1; s <= CORE_LAT; s++)
                tag_id[s] <= tag_id[s-1];
            case ({transfer, fifo_pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_comb begin
        rsp_in        = '0;
        rsp_in.id     = RSP_ID_W'(tag_id[CORE_LAT]);
        rsp_in.result = DEF_RES_W'(core_result);
    end

    assign fifo_push = tag_valid[CORE_LAT];
    assign fifo_pop  = rsp_valid && rsp_ready;

    pattern_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .push  (fifo_push),
        .din   (rsp_in),
        .pop   (fifo_pop),
        .dout  (rsp_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign rsp_valid  = !fifo_empty;
    assign rsp_id     = fifo_empty ? '0 : ID_W'(rsp_head.id);
    assign rsp_result = fifo_empty ? '0 : RES_W'(rsp_head.result);

    // The credit limit guarantees the FIFO has room whenever a result returns.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net)
            assert (!(fifo_push && fifo_full));
    end

endmodule

// File: tb/tb_pattern_eval_scheduler.sv
// Directed bench for pattern_eval_scheduler with a two-stage behavioural
// stand-in for the shared pattern core.
module tb_pattern_eval_scheduler;

    localparam int N_REQ = 4;
    localparam int VEC_W = 15;
    localparam int RES_W = 13;

    localparam logic [VEC_W-1:0] V0 = 15'h01A5;
    localparam logic [VEC_W-1:0] V1 = 15'h2B3C;
    localparam logic [VEC_W-1:0] V2 = 15'h04D2;
    localparam logic [VEC_W-1:0] V3 = 15'h7FFF;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_enable;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*VEC_W-1:0] req_vec;
    logic [N_REQ-1:0]       req_ready;
    logic                   core_launch;
    logic [VEC_W-1:0]       core_vec;
    logic [RES_W-1:0]       core_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [RES_W-1:0]       rsp_result;
    logic                   busy;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-derived grant/response timeline with all four requesters valid.
    logic [3:0] t2_ready [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    logic       t2_rv    [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int         t2_rid   [10] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0};

    assign req_vec = {V3, V2, V1, V0};

    always #5 clk = ~clk;

    pattern_eval_scheduler dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .cfg_enable     (cfg_enable),
        .req_valid      (req_valid),
        .req_vec        (req_vec),
        .req_ready      (req_ready),
        .core_launch    (core_launch),
        .core_vec       (core_vec),
        .core_result    (core_result),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_result     (rsp_result),
        .busy           (busy)
    );

    function automatic logic [RES_W-1:0] core_f(input logic [VEC_W-1:0] v);
        return v[12:0] ^ {v[14:13], 11'h0AB};
    endfunction

    // Core stand-in: result valid exactly two cycles after the launch cycle.
    logic [RES_W-1:0] p0, p1;
    always_ff @(posedge clk) begin
        p0 <= core_f(core_vec);
        p1 <= p0;
    end
    assign core_result = p1;

    function automatic logic [VEC_W-1:0] vec_of(input int i);
        case (i)
            0:       return V0;
            1:       return V1;
            2:       return V2;
            default: return V3;
        endcase
    endfunction

    function automatic logic [RES_W-1:0] res_of(input int i);
        case (i)
            0:       return 13'h010E;
            1:       return 13'h0397;
            2:       return 13'h0479;
            default: return 13'h0754;
        endcase
    endfunction

    function automatic int oh2i(input logic [3:0] oh);
        for (int i = 0; i < 4; i++)
            if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int cycles);
        rsp_ready = 1'b1;
        for (int i = 0; i < cycles; i++)
            step();
        rsp_ready = 1'b0;
        check("drain_empty", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_req_ready",   req_ready,   0);
        check("rst_core_launch", core_launch, 0);
        check("rst_core_vec",    core_vec,    0);
        check("rst_rsp_valid",   rsp_valid,   0);
        check("rst_rsp_id",      rsp_id,      0);
        check("rst_rsp_result",  rsp_result,  0);
        check("rst_busy",        busy,        0);
        rst_n = 1'b1;

        // Single request: grant, launch, response after four cycles
        cfg_enable = 1'b1;
        step();
        check("t1_busy", busy, 1);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("t1_launch", core_launch, 1);
        check("t1_vec", core_vec, 15'h01A5);
        step();
        check("t1_launch_off", core_launch, 0);
        check("t1_vec_hold", core_vec, 15'h01A5);
        step();
        check("t1_rsp_early", rsp_valid, 0);
        step();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_id", rsp_id, 0);
        check("t1_rsp_result", rsp_result, 13'h010E);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t1_popped", rsp_valid, 0);

        // All requesters valid, consumer always ready
        do_reset();
        cfg_enable = 1'b1;
        step();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("t2_ready", req_ready, t2_ready[k]);
            if (k > 0) begin
                check("t2_launch", core_launch, t2_ready[k-1] != 4'h0);
                if (t2_ready[k-1] != 4'h0)
                    check("t2_vec", core_vec, vec_of(oh2i(t2_ready[k-1])));
            end else begin
                check("t2_launch", core_launch, 0);
            end
            check("t2_rsp_valid", rsp_valid, t2_rv[k]);
            if (t2_rv[k]) begin
                check("t2_rsp_id", rsp_id, t2_rid[k]);
                check("t2_rsp_result", rsp_result, res_of(t2_rid[k]));
            end
            step();
        end
        req_valid = '0;
        drain(6);

        // Back-pressure: credit limit stops grants at four outstanding
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("t3_ready", req_ready, (k < 4) ? 4'b0100 : 4'b0000);
            if (k >= 7) begin
                check("t3_count", dut.u_rsp_fifo.count, 4);
                check("t3_rsp_valid", rsp_valid, 1);
                check("t3_rsp_id", rsp_id, 2);
                check("t3_rsp_result", rsp_result, 13'h0479);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("t3_ready_full", req_ready, 4'b0000);
        step();
        check("t3_ready_pop1", req_ready, 4'b0100);
        step();
        check("t3_ready_pop2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        drain(10);

        // Drain with three in flight
        req_valid = 4'b1111;
        #1;
        check("t4_ready_e0", req_ready, 4'b1000);
        step();
        check("t4_ready_e1", req_ready, 4'b0001);
        step();
        check("t4_ready_e2", req_ready, 4'b0010);
        step();
        cfg_enable = 1'b0;
        #1;
        check("t4_ready_cfg_off", req_ready, 4'b0000);
        step();
        for (int k = 0; k < 4; k++) begin
            check("t4_drain_ready", req_ready, 4'b0000);
            check("t4_drain_busy", busy, 1);
            step();
        end
        rsp_ready = 1'b1;
        check("t4_rsp_id0", rsp_id, 3);
        check("t4_rsp_res0", rsp_result, 13'h0754);
        step();
        check("t4_rsp_id1", rsp_id, 0);
        check("t4_rsp_res1", rsp_result, 13'h010E);
        step();
        check("t4_rsp_id2", rsp_id, 1);
        check("t4_rsp_res2", rsp_result, 13'h0397);
        step();
        check("t4_empty", rsp_valid, 0);
        check("t4_busy_last", busy, 1);
        step();
        check("t4_idle", busy, 0);
        check("t4_idle_ready", req_ready, 4'b0000);
        req_valid = '0;
        rsp_ready = 1'b0;

        // Reset with two evaluations in flight and one response queued
        cfg_enable = 1'b1;
        step();
        req_valid = 4'b0001;
        #1;
        check("t5_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        check("t5_queued", rsp_valid, 1);
        check("t5_queued_id", rsp_id, 0);
        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        step();
        check("t5_req_ready",   req_ready,   0);
        check("t5_core_launch", core_launch, 0);
        check("t5_core_vec",    core_vec,    0);
        check("t5_rsp_valid",   rsp_valid,   0);
        check("t5_rsp_id",      rsp_id,      0);
        check("t5_rsp_result",  rsp_result,  0);
        check("t5_busy",        busy,        0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t5_no_stale", rsp_valid, 0);
        end

        // Round-robin wrap after requester 3
        cfg_enable = 1'b1;
        step();
        req_valid = 4'b1000;
        #1;
        check("t6_ready3", req_ready, 4'b1000);
        step();
        req_valid = 4'b1010;
        #1;
        check("t6_launch3", core_vec, V3);
        check("t6_ready1", req_ready, 4'b0010);
        step();
        req_valid = 4'b1000;
        #1;
        check("t6_launch1", core_launch, 1);
        check("t6_vec1", core_vec, V1);
        check("t6_ready3b", req_ready, 4'b1000);
        step();
        req_valid = '0;
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
